result_uart_sender: RTL

//  Downstream of the predictor. Captures the 64-bit prediction result when finished_wire rises,

---
 rtl/result_uart_sender_pkg.sv | 20 ++
 rtl/result_uart_sender_uart_tx_byte.sv | 104 ++++++++++
 rtl/result_uart_sender.sv | 117 +++++++++++
 3 files changed

// File: rtl/result_uart_sender_pkg.sv
// Shared UART framing constants and state encodings for the result sender.
package result_uart_sender_pkg;

    localparam logic        START_BIT = 1'b0;
    localparam logic        STOP_BIT  = 1'b1;
    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } uart_state_e;

    typedef enum logic {
        SEQ_IDLE,
        SEQ_SEND
    } seq_state_e;

endpackage

// File: rtl/result_uart_sender_uart_tx_byte.sv
// One 8N1 UART frame per accepted byte; ready rises on the final stop-bit cycle so a
// byte presented then starts its start bit on the very next cycle.
module uart_tx_byte
    import result_uart_sender_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int unsigned           TIMER_W   = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0]    TIMER_MAX = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]            LAST_BIT  = 3'(DATA_BITS - 1);

    uart_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         bit_idx_q, bit_idx_d;
    logic [7:0]         data_q, data_d;
    logic               tx_q, tx_d;
    logic               tick;

    assign tick  = (timer_q == TIMER_MAX);
    assign ready = (state_q == ST_IDLE) || ((state_q == ST_STOP) && tick);
    assign tx    = tx_q;

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        tx_d      = tx_q;
        if (state_q == ST_IDLE || tick) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + TIMER_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (valid) begin
                    state_d = ST_START;
                    data_d  = data;
                    tx_d    = START_BIT;
                end
            end
            ST_START: begin
                if (tick) begin
                    state_d   = ST_DATA;
                    bit_idx_d = '0;
                    tx_d      = data_q[0];
                end
            end
            ST_DATA: begin
                if (tick) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = ST_STOP;
                        tx_d    = STOP_BIT;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        data_d    = data_q >> 1;
                        tx_d      = data_q[1];
                    end
                end
            end
            ST_STOP: begin
                if (tick) begin
                    if (valid) begin
                        state_d = ST_START;
                        data_d  = data;
                        tx_d    = START_BIT;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = STOP_BIT;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = STOP_BIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            data_q    <= '0;
            tx_q      <= STOP_BIT;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            tx_q      <= tx_d;
        end
    end

endmodule

// File: rtl/result_uart_sender.sv
// Captures the predictor result on a rising finished edge and streams it LSB byte first
// as NUM_BYTES back-to-back UART frames.
module result_uart_sender
    import result_uart_sender_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned NUM_BYTES    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [8*NUM_BYTES-1:0] result_in,
    input  logic                   finished,
    output logic                   tx,
    output logic                   busy,
    output logic                   done,
    output logic                   overrun
);

    localparam int unsigned        RESULT_W = 8 * NUM_BYTES;
    localparam int unsigned        IDX_W    = $clog2(NUM_BYTES) + 1;
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_BYTES - 1);

    seq_state_e          state_q, state_d;
    logic [RESULT_W-1:0] shift_q, shift_d;
    logic [IDX_W-1:0]    byte_idx_q, byte_idx_d;
    logic                finished_dly_q;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                overrun_q, overrun_d;
    logic                req;
    logic                tx_valid;
    logic                tx_ready;
    logic [7:0]          tx_data;

    assign req     = finished & ~finished_dly_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign overrun = overrun_q;

    // shift_q holds only the bytes not yet handed to the frame sender; byte 0 goes
    // straight from result_in so its start bit begins the cycle after req.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        byte_idx_d = byte_idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        overrun_d  = overrun_q;
        tx_valid   = 1'b0;
        tx_data    = result_in[7:0];

        case (state_q)
            SEQ_IDLE: begin
                tx_valid = req;
                if (req) begin
                    state_d    = SEQ_SEND;
                    shift_d    = result_in >> 8;
                    byte_idx_d = '0;
                    busy_d     = 1'b1;
                end
            end
            SEQ_SEND: begin
                tx_valid = (byte_idx_q < LAST_IDX);
                tx_data  = shift_q[7:0];
                if (req) begin
                    overrun_d = 1'b1;
                end
                if (tx_ready) begin
                    if (tx_valid) begin
                        shift_d    = shift_q >> 8;
                        byte_idx_d = byte_idx_q + IDX_W'(1);
                    end else begin
                        state_d = SEQ_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = SEQ_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= SEQ_IDLE;
            shift_q        <= '0;
            byte_idx_q     <= '0;
            finished_dly_q <= 1'b1;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            byte_idx_q     <= byte_idx_d;
            finished_dly_q <= finished;
            busy_q         <= busy_d;
            done_q         <= done_d;
            overrun_q      <= overrun_d;
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_tx_byte (
        .clk  (clk),
        .rst  (rst),
        .data (tx_data),
        .valid(tx_valid),
        .ready(tx_ready),
        .tx   (tx)
    );

endmodule
